// File: rtl/ram8_if.sv
// RAM8 bus: address/write-data/write-enable from the tester, read data back.
`timescale 1ns/1ps
interface ram8_if #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 3
);
   logic [ADDRESS_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0]    in;
   logic [DATA_WIDTH-1:0]    out;
   logic                     load;

   modport master (output address, in, load, input out);
   modport slave  (input address, in, load, output out);
endinterface

// File: rtl/ram8_tester.sv
// Built-in self test for a RAM8: writes pat^addr, reads it back, then repeats with
// the inverted words, counting mismatches and recording the first failing address.
//
// state   | meaning
// IDLE    | waiting for start
// WR      | write D(a) at address a
// RD_SET  | present address a for read
// RD_CMP  | compare out with D(a)
// WRI     | write ~D(a) at address a
// RDI_SET | present address a for inverse read
// RDI_CMP | compare out with ~D(a)
// FIN     | one-cycle done pulse, result valid
`timescale 1ns/1ps
module ram8_tester #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    pattern,
   ram8_if.master                   ram,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [3:0]               err_count,
   output logic [ADDRESS_WIDTH-1:0] fail_addr
);

   typedef enum logic [2:0] {
      IDLE, WR, RD_SET, RD_CMP, WRI, RDI_SET, RDI_CMP, FIN
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] addr_one = 1;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0]    pat;
   logic [DATA_WIDTH-1:0]    word;
   logic [DATA_WIDTH-1:0]    exp_word;
   logic                     last;
   logic                     inv;
   logic                     cmp;
   logic                     mismatch;

   assign last     = &a;
   assign word     = pat ^ {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, a};
   assign inv      = (state == WRI) || (state == RDI_SET) || (state == RDI_CMP);
   assign exp_word = inv ? ~word : word;
   assign cmp      = (state == RD_CMP) || (state == RDI_CMP);
   assign mismatch = cmp && (ram.out != exp_word);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WR;
         WR:      if (last) state_nxt = RD_SET;
         RD_SET:  state_nxt = RD_CMP;
         RD_CMP:  state_nxt = last ? WRI : RD_SET;
         WRI:     if (last) state_nxt = RDI_SET;
         RDI_SET: state_nxt = RDI_CMP;
         RDI_CMP: state_nxt = last ? FIN : RDI_SET;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram.address = a;
      ram.load    = (state == WR) || (state == WRI);
      ram.in      = ram.load ? exp_word : '0;
      busy        = (state != IDLE) && (state != FIN);
      done        = (state == FIN);
   end

   // Address counter wraps 7 -> 0 naturally at each phase boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a         <= '0;
         pat       <= '0;
         err_count <= '0;
         fail_addr <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pat       <= pattern;
                  err_count <= '0;
                  fail_addr <= '0;
                  pass      <= 1'b0;
                  a         <= '0;
               end
            end
            WR, WRI: a <= a + addr_one;
            RD_CMP, RDI_CMP: begin
               a <= a + addr_one;
               if (mismatch) begin
                  if (err_count != 4'd15) err_count <= err_count + 4'd1;
                  if (err_count == 4'd0)  fail_addr <= a;
               end
               if (state == RDI_CMP && last)
                  pass <= (err_count == 4'd0) && !mismatch;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram8_tester.sv
// Self-checking bench: RAM8 model with fault modes, write and result scoreboards.
`timescale 1ns/1ps
module tb_ram8_tester;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] pattern;
   logic        busy, done, pass;
   logic [3:0]  err_count;
   logic [2:0]  fail_addr;

   int tests = 0;
   int fails = 0;
   int ram_mode = 0;   // 0 ideal, 1 addr1 bit0 stuck-at-0, 2 out tied to 0

   typedef struct packed { logic [2:0] a; logic [15:0] d; } wr_t;
   typedef struct packed { logic p; logic [3:0] e; logic [2:0] f; } res_t;
   wr_t  wq[$];
   res_t rq[$];

   logic [15:0] mem [8];

   ram8_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) bus ();

   ram8_tester #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pattern   (pattern),
      .ram       (bus.master),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_addr (fail_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.load)
         mem[bus.address] <= (ram_mode == 1 && bus.address == 3'd1) ? (bus.in & 16'hFFFE) : bus.in;

   always_comb bus.out = (ram_mode == 2) ? 16'h0000 : mem[bus.address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.load) begin
            chk("write_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               wr_t w;
               w = wq.pop_front();
               chk("write_addr", 32'(bus.address), 32'(w.a));
               chk("write_data", 32'(bus.in), 32'(w.d));
            end
         end else begin
            chk("in_zero_when_idle", 32'(bus.in), 0);
         end
      end
   end

   task automatic push_exp(input logic [15:0] pat, input logic p, input logic [3:0] e, input logic [2:0] f);
      logic [2:0] aa;
      for (int i = 0; i < 8; i++) begin
         aa = 3'(i);
         wq.push_back('{a: aa, d: pat ^ {13'b0, aa}});
      end
      for (int i = 0; i < 8; i++) begin
         aa = 3'(i);
         wq.push_back('{a: aa, d: ~(pat ^ {13'b0, aa})});
      end
      rq.push_back('{p: p, e: e, f: f});
   endtask

   // Leaves the bench at the negedge right after the accepting edge E0.
   task automatic launch(input logic [15:0] pat, input int mode, input bit hold,
                         input logic p, input logic [3:0] e, input logic [2:0] f);
      @(negedge clk);
      ram_mode = mode;
      pattern  = pat;
      start    = 1'b1;
      push_exp(pat, p, e, f);
      @(negedge clk);
      if (!hold) start = 1'b0;
      pattern = ~pat;
      chk("busy_after_start", 32'(busy), 1);
      chk("err_cleared_at_start", 32'(err_count), 0);
   endtask

   task automatic finish(input int restart_at, input int reset_at, input bit hold);
      int   k;
      int   dcnt;
      res_t r;
      k = 0;
      while (k < 60 && done !== 1'b1) begin
         if (k == restart_at) start = 1'b1;
         else if (restart_at >= 0 && k == restart_at + 1) start = 1'b0;
         if (k == reset_at) begin
            reset = 1'b1;
            #1;
            chk("reset_busy", 32'(busy), 0);
            chk("reset_load", 32'(bus.load), 0);
            chk("reset_done", 32'(done), 0);
            chk("reset_addr", 32'(bus.address), 0);
            chk("reset_err", 32'(err_count), 0);
            wq.delete();
            rq.delete();
            @(negedge clk);
            reset = 1'b0;
            dcnt = 0;
            for (int i = 0; i < 60; i++) begin
               @(negedge clk);
               if (done === 1'b1) dcnt++;
            end
            chk("no_done_after_abort", 32'(dcnt), 0);
            return;
         end
         @(negedge clk);
         k++;
      end
      chk("done_seen", 32'(done), 1);
      chk("done_latency", 32'(k), 48);
      chk("busy_low_at_done", 32'(busy), 0);
      chk("result_queued", 32'(rq.size()), 1);
      r = (rq.size() > 0) ? rq.pop_front() : '0;
      chk("pass", 32'(pass), 32'(r.p));
      chk("err_count", 32'(err_count), 32'(r.e));
      chk("fail_addr", 32'(fail_addr), 32'(r.f));
      chk("all_writes_seen", 32'(wq.size()), 0);
      if (!hold) begin
         @(negedge clk);
         chk("done_single_cycle", 32'(done), 0);
         chk("pass_held", 32'(pass), 32'(r.p));
         chk("err_held", 32'(err_count), 32'(r.e));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      reset   = 1'b1;
      start   = 1'b0;
      pattern = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_err", 32'(err_count), 0);
      chk("rst_fail_addr", 32'(fail_addr), 0);
      chk("rst_load", 32'(bus.load), 0);
      chk("rst_in", 32'(bus.in), 0);
      reset = 1'b0;

      // Ideal RAM
      launch(16'hA5A5, 0, 1'b0, 1'b1, 4'd0, 3'd0);
      finish(-1, -1, 1'b0);

      // Stuck-at-0 on bit0 of address 1: only the true-phase read of addr 1 fails
      launch(16'h0000, 1, 1'b0, 1'b0, 4'd1, 3'd1);
      finish(-1, -1, 1'b0);

      // Read data tied low: 16 mismatches saturate at 15
      launch(16'h5555, 2, 1'b0, 1'b0, 4'd15, 3'd0);
      finish(-1, -1, 1'b0);

      // Second start mid-test is ignored
      launch(16'h3C3C, 0, 1'b0, 1'b1, 4'd0, 3'd0);
      finish(10, -1, 1'b0);

      // Reset mid-test aborts with no done
      launch(16'h1111, 0, 1'b0, 1'b1, 4'd0, 3'd0);
      finish(-1, 20, 1'b0);

      // Reset dominates a simultaneous start
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("reset_beats_start", 32'(busy), 0);
      reset = 1'b0;
      start = 1'b0;

      // First start after reset runs a complete test
      launch(16'hFFFF, 0, 1'b0, 1'b1, 4'd0, 3'd0);
      finish(-1, -1, 1'b0);

      // Back-to-back with start held high through FIN
      launch(16'h5555, 2, 1'b1, 1'b0, 4'd15, 3'd0);
      finish(-1, -1, 1'b1);
      pattern  = 16'h1234;
      ram_mode = 0;
      push_exp(16'h1234, 1'b1, 4'd0, 3'd0);
      @(negedge clk);
      chk("b2b_idle_busy", 32'(busy), 0);
      chk("b2b_idle_done", 32'(done), 0);
      chk("b2b_err_held", 32'(err_count), 15);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accepted", 32'(busy), 1);
      chk("b2b_err_cleared", 32'(err_count), 0);
      finish(-1, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram8_tester.md
RAM8_TESTER -- requirements
Module: ram8_tester

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, as the memory word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 3, as the memory address width (8 words).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  request to run one full test; sampled only in IDLE.
REQ-007 Port pattern  input  DATA_WIDTH  base test pattern; captured when start is accepted.
REQ-008 Port address  output  ADDRESS_WIDTH  address driven to the RAM8.
REQ-009 Port in  output  DATA_WIDTH  write data driven to the RAM8.
REQ-010 Port load  output  1  RAM8 write enable; the RAM8 captures in on the rising edge where load=1.
REQ-011 Port out  input  DATA_WIDTH  RAM8 read data.
REQ-012 Port busy  output  1  high while a test is in progress.
REQ-013 Port done  output  1  single-cycle pulse at test completion.
REQ-014 Port pass  output  1  1 when the last completed test had zero mismatches.
REQ-015 Port err_count  output  4  saturating mismatch count for the current or last test.
REQ-016 Port fail_addr  output  ADDRESS_WIDTH  address of the first mismatch in the current or last test.

Function
REQ-017 The block SHALL implement states IDLE, WR, RD_SET, RD_CMP, WRI, RDI_SET, RDI_CMP, and FIN.
REQ-018 The expected word for address a SHALL be D(a) = pat ^ zero-extended a, where pat is the captured pattern; the inverse word SHALL be ~D(a).
REQ-019 IDLE with start=1: capture pattern, clear err_count, fail_addr and pass, set the address counter to 0, and go to WR.
REQ-020 WR: drive address=a, in=D(a), load=1 for one cycle per address; a increments 0..7; after a=7, go to RD_SET with a=0.
REQ-021 RD_SET: drive address=a with load=0 for one cycle, then go to RD_CMP; address SHALL be held through RD_CMP.
REQ-022 RD_CMP: compare out with D(a); after a=7, go to WRI, otherwise go to RD_SET with a+1.
REQ-023 WRI, RDI_SET and RDI_CMP SHALL behave as WR, RD_SET and RD_CMP but use ~D(a); after RDI_CMP at a=7, go to FIN.
REQ-024 Mismatch handling: err_count SHALL increment and saturate at 15; on the first mismatch of a test only, fail_addr SHALL capture a.
REQ-025 FIN: done=1 for exactly one cycle; pass=(err_count==0 including the final compare); busy=0; go to IDLE.
REQ-026 Latency: start accepted at edge E0 -> done high from edge E48 to E49 (8+16+8+16 cycles).
REQ-027 busy SHALL be 1 from E0 until the edge at which done rises.
REQ-028 load SHALL be 0 in every state except WR and WRI.
REQ-029 When load=0, in SHALL be 0.
REQ-030 start outside IDLE SHALL be ignored; pattern changes after acceptance SHALL have no effect.
REQ-031 pass, err_count and fail_addr SHALL hold after FIN until the next accepted start.
REQ-032 start high in the FIN cycle SHALL be ignored; start high in the following IDLE cycle SHALL be accepted.

Reset
REQ-033 When reset=1, the block SHALL immediately (asynchronously) force state=IDLE, address=0, in=0, load=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0.
REQ-034 Reset mid-test SHALL abort the test with no done pulse; RAM contents are don't-care.
REQ-035 Reset SHALL win over a simultaneous start.
REQ-036 The first start after reset is released SHALL run a complete test.

Verification
REQ-037 Ideal RAM8 model, pattern=16'hA5A5, start pulse -> write at address 2 is 16'hA5A7 and inverse write at address 2 is 16'h5A58; done at cycle 48; pass=1, err_count=0.
REQ-038 RAM8 model with address 1 bit0 stuck-at-0, pattern=16'h0000 -> err_count=1, fail_addr=1, pass=0 at done.
REQ-039 out tied to 16'h0000, pattern=16'h5555 -> all 16 compares mismatch; err_count=15 (saturated), fail_addr=0, pass=0.
REQ-040 Second start pulse at cycle 10 during a test -> exactly one done pulse at cycle 48; result unaffected.
REQ-041 reset asserted at cycle 20 -> load=0 and busy=0 in the same cycle, no done pulse; a subsequent start with pattern=16'hFFFF gives pass=1 after 48 cycles.
REQ-042 Back-to-back runs with start held high -> second test accepted the cycle after FIN; err_count cleared at the second acceptance.
